single_min_reduce: RTL and testbench
====================================

// Module: single_min_reduce
// PURPOSE
//  Streaming reduction stage downstream of the single-precision min datapath: consumes
//  frames of IEEE-754 binary32 values (valid/ready, last-marked) and emits one result per
//  frame: frame minimum, element count and an all-NaN flag. Feeds result FIFOs/host readout.
// PARAMETERS
//  COUNT_W  16  width of element counter and index; counter saturates at 2**COUNT_W-1
// PORTS
//  clk        in   1        clock; all logic on rising edge
//  rst_n      in   1        synchronous reset, active-low
//  in_data    in   32       binary32 element
//  in_valid   in   1        in_data valid
//  in_last    in   1        element is last of frame (qualified by in_valid)
//  in_ready   out  1        stage accepts element this cycle
//  out_data   out  32       frame minimum
//  out_count  out  COUNT_W  elements in frame (saturating)
//  out_all_nan out 1        every element of frame was NaN
//  out_valid  out  1        result valid; held until out_ready
//  out_ready  in   1        downstream accepts result
// BEHAVIOUR
//  - Transfer on in_valid&in_ready; result transfer on out_valid&out_ready.
//  - FSM: FIRST (awaiting first element) -> ACCUM (after non-last element) -> HOLD (after
//    last element). FIRST->HOLD on single-element frame. HOLD->FIRST on result transfer.
//  - in_ready = (state != HOLD); one bubble cycle per frame after result drains.
//  - Latency: out_valid high the cycle after the last element is accepted.
//  - FIRST load: acc<=in_data, cnt<=1. ACCUM: acc<=min(acc,in_data), cnt<=sat(cnt+1).
//  - min rules: NaN = exp 8'hFF & mant!=0; NaN operand loses to non-NaN; -0 < +0;
//    otherwise numeric order via sign-magnitude compare; -inf/+inf ordinary values.
//    Ties (bit-identical) keep accumulator. NaN payloads never propagate.
//  - out_all_nan=1 and out_data=32'h7FC00000 (canonical qNaN) iff all elements NaN.
//  - out_data/out_count/out_all_nan stable while out_valid && !out_ready.
//  - Reset: state FIRST, out_valid 0, out_data 0, out_count 0, out_all_nan 0,
//    in_ready 1 the cycle after reset released. Reset mid-frame discards partial frame;
//    reset while HOLD drops pending result.
//  - in_last with in_valid low is ignored; X on in_data while !in_valid must not alter state.
// CONFIGURATION
//  MIN_REDUCE_INDEX_EN defined: adds port out_index [COUNT_W-1:0] = zero-based position of
//  the first element achieving the minimum (0 if all NaN; positions past saturation clamp
//  to 2**COUNT_W-1); reset value 0, held with out_data.
//  Undefined: port and index register absent; all other behaviour identical.
// STRUCTURE
//  - single_pkg: constants SINGLE_QNAN=32'h7FC00000, SINGLE_POS_INF=32'h7F800000;
//    functions single_is_nan(x), single_is_neg_zero(x); FSM state enum.
//  - Sub-module single_lt: combinational, lt = (b strictly precedes a) per min rules above;
//    instanced once between acc and in_data.
// TESTING
//  1. Frame {3F800000,C0000000,40400000}, last on 3rd -> out_data C0000000, count 3,
//     all_nan 0, (INDEX_EN) index 1; out_valid 1 cycle after 3rd accept.
//  2. Frame {00000000,80000000} -> out_data 80000000; reversed order -> 80000000 too.
//  3. Frame {7FC00001,3F800000,FF800000} -> out_data FF800000, count 3; frame
//     {7FC00001,7F800001} -> out_data 7FC00000, all_nan 1, count 2.
//  4. Single-element frame {40400000} with out_ready held 0 for 5 cycles -> in_ready 0,
//     outputs stable throughout; out_ready 1 -> next cycle in_ready 1.
//  5. rst_n low after 2 elements of a frame, then frame {3F800000} -> result 3F800000,
//     count 1 (no carry-over); all outputs match reset values while rst_n low.
//  6. COUNT_W=2, 5-element frame of 3F800000 -> count 3 (saturated), index 0.

Source files
------------

// File: rtl/single_pkg.sv
// Shared binary32 constants, classification helpers and FSM encoding for the
// single-precision min reduction stage.
package single_pkg;

  localparam logic [31:0] SINGLE_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] SINGLE_POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  function automatic logic single_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic single_is_neg_zero(input logic [31:0] x);
    return x == 32'h8000_0000;
  endfunction

  // Maps sign-magnitude onto an unsigned total order (-0 sorts just below +0).
  function automatic logic [31:0] single_order_key(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

endpackage

// File: rtl/single_lt.sv
// Combinational precedence test: lt is high when b strictly precedes a under
// min ordering (NaN loses to any number, -0 below +0, ties keep a).
module single_lt
  import single_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        lt
);

  logic a_nan;
  logic b_nan;
  logic key_lt;

  assign a_nan  = single_is_nan(a);
  assign b_nan  = single_is_nan(b);
  assign key_lt = single_order_key(b) < single_order_key(a);
  assign lt     = !b_nan && (a_nan || key_lt);

endmodule

// File: rtl/single_min_reduce.sv
// Per-frame binary32 minimum, saturating element count and all-NaN flag.
// Optional MIN_REDUCE_INDEX_EN adds out_index (position of first minimum).
module single_min_reduce
  import single_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [31:0]        out_data,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_all_nan,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MIN_REDUCE_INDEX_EN
  ,
  output logic [COUNT_W-1:0] out_index
`endif
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  state_e             state;
  state_e             state_d;
  logic               in_fire;
  logic               in_nan;
  logic               in_lt;
  logic [31:0]        acc_d;
  logic [COUNT_W-1:0] cnt_d;
  logic               all_nan_d;
`ifdef MIN_REDUCE_INDEX_EN
  logic [COUNT_W-1:0] idx_d;
`endif

  assign in_fire = in_valid && in_ready;
  assign in_nan  = single_is_nan(in_data);

  single_lt u_lt (
    .a  (out_data),
    .b  (in_data),
    .lt (in_lt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_FIRST;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_FIRST: if (in_fire) state_d = in_last ? ST_HOLD : ST_ACCUM;
      ST_ACCUM: if (in_fire && in_last) state_d = ST_HOLD;
      ST_HOLD:  if (out_valid && out_ready) state_d = ST_FIRST;
      default:  state_d = ST_FIRST;
    endcase
  end

  // Next values of the accumulator; the accumulator doubles as out_data.
  always_comb begin
    acc_d     = out_data;
    cnt_d     = out_count;
    all_nan_d = out_all_nan;
`ifdef MIN_REDUCE_INDEX_EN
    idx_d     = out_index;
`endif
    if (in_fire) begin
      if (state == ST_FIRST) begin
        acc_d     = in_nan ? SINGLE_QNAN : in_data;
        cnt_d     = CNT_ONE;
        all_nan_d = in_nan;
`ifdef MIN_REDUCE_INDEX_EN
        idx_d     = '0;
`endif
      end else if (state == ST_ACCUM) begin
        if (in_lt) begin
          acc_d = in_data;
`ifdef MIN_REDUCE_INDEX_EN
          idx_d = out_count;
`endif
        end
        cnt_d     = (out_count == CNT_MAX) ? out_count : out_count + CNT_ONE;
        all_nan_d = out_all_nan && in_nan;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_count   <= '0;
      out_all_nan <= 1'b0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
`ifdef MIN_REDUCE_INDEX_EN
      out_index   <= '0;
`endif
    end else begin
      out_data    <= acc_d;
      out_count   <= cnt_d;
      out_all_nan <= all_nan_d;
      out_valid   <= (state_d == ST_HOLD);
      in_ready    <= (state_d != ST_HOLD);
`ifdef MIN_REDUCE_INDEX_EN
      out_index   <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_single_min_reduce.sv
// Directed bench for single_min_reduce with a frame-level reference model.
module tb_single_min_reduce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid, in_last, in_ready;
  logic [31:0] out_data;
  logic [15:0] out_count;
  logic        out_all_nan, out_valid, out_ready;

  logic [31:0] in_data2;
  logic        in_valid2, in_last2, in_ready2;
  logic [31:0] out_data2;
  logic [1:0]  out_count2;
  logic        out_all_nan2, out_valid2, out_ready2;
`ifdef MIN_REDUCE_INDEX_EN
  logic [15:0] out_index;
  logic [1:0]  out_index2;
`endif

  always #5 clk = ~clk;

  single_min_reduce #(.COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_count(out_count), .out_all_nan(out_all_nan), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MIN_REDUCE_INDEX_EN
    , .out_index(out_index)
`endif
  );

  single_min_reduce #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_last(in_last2), .in_ready(in_ready2), .out_data(out_data2),
    .out_count(out_count2), .out_all_nan(out_all_nan2), .out_valid(out_valid2),
    .out_ready(out_ready2)
`ifdef MIN_REDUCE_INDEX_EN
    , .out_index(out_index2)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    int          count;
    bit          nan;
    int          idx;
  } res_t;

  res_t        exp_q[$];
  logic [31:0] cur[$];
  bit          armed = 0;
  bit          rst_q = 0;

  function automatic bit m_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  // b strictly below a, both numbers
  function automatic bit m_less(input logic [31:0] b, input logic [31:0] a);
    if (b == a) return 0;
    if (b[31] != a[31]) return b[31];
    if (!b[31]) return b[30:0] < a[30:0];
    return b[30:0] > a[30:0];
  endfunction

  function automatic res_t model(input logic [31:0] f[$]);
    res_t r;
    int best = -1;
    foreach (f[i])
      if (!m_nan(f[i]) && (best < 0 || m_less(f[i], f[best]))) best = i;
    r.count = (f.size() > 65535) ? 65535 : f.size();
    if (best < 0) begin
      r.data = 32'h7FC00000; r.nan = 1; r.idx = 0;
    end else begin
      r.data = f[best]; r.nan = 0; r.idx = (best > 65535) ? 65535 : best;
    end
    return r;
  endfunction

  // Compare process for the main instance.
  always @(negedge clk) begin
    if (armed && rst_q) begin
      chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 0);
      chk(out_data == 32'h0, "rst_out_data", 64'(out_data), 0);
      chk(out_count == 16'h0, "rst_out_count", 64'(out_count), 0);
      chk(out_all_nan == 1'b0, "rst_all_nan", 64'(out_all_nan), 0);
      chk(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 1);
`ifdef MIN_REDUCE_INDEX_EN
      chk(out_index == 16'h0, "rst_out_index", 64'(out_index), 0);
`endif
    end else if (armed) begin
      chk(out_valid == (exp_q.size() != 0), "out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk(in_ready == !out_valid, "in_ready", 64'(in_ready), 64'(!out_valid));
      if (out_valid && exp_q.size() != 0) begin
        chk(out_data == exp_q[0].data, "mdl_data", 64'(out_data), 64'(exp_q[0].data));
        chk(int'(out_count) == exp_q[0].count, "mdl_count", 64'(out_count), 64'(exp_q[0].count));
        chk(out_all_nan == exp_q[0].nan, "mdl_all_nan", 64'(out_all_nan), 64'(exp_q[0].nan));
`ifdef MIN_REDUCE_INDEX_EN
        chk(int'(out_index) == exp_q[0].idx, "mdl_index", 64'(out_index), 64'(exp_q[0].idx));
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        cur.push_back(in_data);
        if (in_last) begin
          exp_q.push_back(model(cur));
          cur.delete();
        end
      end
    end
    if (!rst_n) begin
      armed = 1; rst_q = 1;
      cur.delete(); exp_q.delete();
    end else begin
      rst_q = 0;
    end
  end

  // ---------------- drivers ----------------
  logic [31:0] fr[$];

  task automatic idle();
    in_valid = 0;
    in_data  = $urandom;
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input bit end_last);
    foreach (fr[i]) begin
      int budget = 50;
      in_valid = 1;
      in_data  = fr[i];
      in_last  = end_last && (i == fr.size() - 1);
      while (!in_ready && budget > 0) begin
        @(posedge clk); #1; budget--;
      end
      if (budget == 0) chk(0, "in_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic get_result(input string name, input logic [31:0] d, input int c, input bit n,
                            input int ix, input int hold);
    int budget = 50;
    while (!out_valid && budget > 0) begin
      @(posedge clk); #1; budget--;
    end
    chk(out_valid == 1'b1, {name, "_valid"}, 64'(out_valid), 1);
    chk(out_data == d, {name, "_data"}, 64'(out_data), 64'(d));
    chk(int'(out_count) == c, {name, "_count"}, 64'(out_count), 64'(c));
    chk(out_all_nan == n, {name, "_all_nan"}, 64'(out_all_nan), 64'(n));
`ifdef MIN_REDUCE_INDEX_EN
    chk(int'(out_index) == ix, {name, "_index"}, 64'(out_index), 64'(ix));
`else
    if (ix < 0) chk(0, {name, "_index_arg"}, 64'(ix), 0);
`endif
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk(in_ready == 1'b0, {name, "_hold_in_ready"}, 64'(in_ready), 0);
      chk(out_valid && out_data == d && int'(out_count) == c, {name, "_hold_stable"},
          64'(out_data), 64'(d));
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk(in_ready == 1'b1, {name, "_ready_after_drain"}, 64'(in_ready), 1);
  endtask

  initial begin
    rst_n = 0;
    out_ready = 0;
    idle();
    in_valid2 = 0; in_data2 = 0; in_last2 = 0; out_ready2 = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // 1. basic minimum and latency
    fr = '{32'h3F800000, 32'hC0000000, 32'h40400000};
    send_frame(1);
    chk(out_valid == 1'b1, "t1_latency", 64'(out_valid), 1);
    get_result("t1", 32'hC0000000, 3, 0, 1, 0);

    // 2. signed zeros in both orders
    fr = '{32'h00000000, 32'h80000000};
    send_frame(1);
    get_result("t2a", 32'h80000000, 2, 0, 1, 0);
    fr = '{32'h80000000, 32'h00000000};
    send_frame(1);
    get_result("t2b", 32'h80000000, 2, 0, 0, 0);

    // 3. NaN handling
    fr = '{32'h7FC00001, 32'h3F800000, 32'hFF800000};
    send_frame(1);
    get_result("t3a", 32'hFF800000, 3, 0, 2, 0);
    fr = '{32'h7FC00001, 32'h7F800001};
    send_frame(1);
    get_result("t3b", 32'h7FC00000, 2, 1, 0, 0);

    // ties keep the first occurrence; +inf is an ordinary value
    fr = '{32'h7F800000, 32'h41200000, 32'hFFC00000, 32'h41200000};
    send_frame(1);
    get_result("tie", 32'h41200000, 4, 0, 1, 0);

    // 4. single element with backpressure
    fr = '{32'h40400000};
    send_frame(1);
    get_result("t4", 32'h40400000, 1, 0, 0, 5);

    // 5. reset mid-frame
    fr = '{32'hC1000000, 32'hC2000000};
    send_frame(0);
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    fr = '{32'h3F800000};
    send_frame(1);
    get_result("t5", 32'h3F800000, 1, 0, 0, 0);

    // 6. count saturation on the narrow instance
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1; in_data2 = 32'h3F800000; in_last2 = (i == 4);
      chk(in_ready2 == 1'b1, "t6_in_ready", 64'(in_ready2), 1);
      @(posedge clk); #1;
    end
    in_valid2 = 0; in_last2 = 0;
    chk(out_valid2 == 1'b1, "t6_valid", 64'(out_valid2), 1);
    chk(out_count2 == 2'd3, "t6_count", 64'(out_count2), 3);
    chk(out_data2 == 32'h3F800000, "t6_data", 64'(out_data2), 64'h3F800000);
    chk(out_all_nan2 == 1'b0, "t6_all_nan", 64'(out_all_nan2), 0);
`ifdef MIN_REDUCE_INDEX_EN
    chk(out_index2 == 2'd0, "t6_index", 64'(out_index2), 0);
`endif
    out_ready2 = 1;
    @(posedge clk); #1;
    out_ready2 = 0;
    chk(in_ready2 == 1'b1, "t6_drain", 64'(in_ready2), 1);

    repeat (3) @(posedge clk);
    chk(exp_q.size() == 0, "model_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
